serial_subtractor: RTL and testbench

Bit-serial, LSB-first two's-complement subtractor. It computes diff = a_in - b_in - borrow_in over WIDTH shift cycles using a single full-subtractor cell and a registered borrow. It is the subtraction counterpart of the full-adder datapath. It sits in the dataflow arithmetic group as a compact, low-area alternative to a ripple subtractor, driven by a simple start/done handshake.

---
 rtl/serial_subtractor_pkg.sv | 14 +
 rtl/serial_subtractor_full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 123 ++++++++++++
 tb/tb_serial_subtractor.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared state encoding and counter width helper for serial_subtractor
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// rtl/serial_subtractor_full_subtractor.sv - one-bit combinational full subtractor cell
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor with start/done handshake
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             borrow_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             diff_bit
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_load;
  logic               w_shift;
  logic               w_last;
  logic               w_bit_d;
  logic               w_bit_bout;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_res;
  logic               r_borrow;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_diff;
  logic               r_borrow_out;
  logic               r_diff_bit;

  full_subtractor u_cell (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_borrow),
    .d    (w_bit_d),
    .bout (w_bit_bout)
  );

  // Start is only honoured outside SHIFT, which also gives back-to-back from DONE
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        w_shift = 1'b1;
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a          <= '0;
      r_b          <= '0;
      r_res        <= '0;
      r_borrow     <= 1'b0;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
      r_diff_bit   <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_load) begin
        r_a      <= a_in;
        r_b      <= b_in;
        r_borrow <= borrow_in;
        r_cnt    <= '0;
        r_busy   <= 1'b1;
      end else if (w_shift) begin
        r_a        <= r_a >> 1;
        r_b        <= r_b >> 1;
        r_borrow   <= w_bit_bout;
        r_res      <= {w_bit_d, r_res[WIDTH-1:1]};
        r_diff_bit <= w_bit_d;
        r_cnt      <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_busy       <= 1'b0;
          r_diff       <= {w_bit_d, r_res[WIDTH-1:1]};
          r_borrow_out <= w_bit_bout;
        end
      end
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign diff       = r_diff;
  assign borrow_out = r_borrow_out;
  assign diff_bit   = r_diff_bit;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor against an arithmetic model
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         borrow_in;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         diff_bit;

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .borrow_in  (borrow_in),
    .a_in       (a_in),
    .b_in       (b_in),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .diff_bit   (diff_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int unsigned full;
    logic [W-1:0] d;
    logic         bo;
    full = int'(a) - int'(b) - int'(bin);
    d    = W'(full);
    bo   = (int'(a) < int'(b) + int'(bin));
    return {bo, d};
  endfunction

  task automatic run_and_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    logic [W:0]   exp;
    logic [W-1:0] bits;
    int           cycles;
    int           busy_cnt;
    exp  = model(a, b, bin);
    bits = '0;
    @(negedge clk);
    a_in = a; b_in = b; borrow_in = bin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    cycles = 0;
    while (!done && cycles < 4 * W) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles <= W) bits[cycles-1] = diff_bit;
      if (busy) busy_cnt++;
    end
    checks++;
    if (cycles !== W) begin errors++; $display("FAIL %s latency: got %0d need %0d", name, cycles, W); end
    checks++;
    if (diff !== exp[W-1:0]) begin errors++; $display("FAIL %s diff: got %0d need %0d", name, diff, exp[W-1:0]); end
    checks++;
    if (borrow_out !== exp[W]) begin errors++; $display("FAIL %s borrow_out: got %0b need %0b", name, borrow_out, exp[W]); end
    checks++;
    if (busy_cnt !== W) begin errors++; $display("FAIL %s busy_cycles: got %0d need %0d", name, busy_cnt, W); end
    checks++;
    if (bits !== exp[W-1:0]) begin errors++; $display("FAIL %s diff_bit_seq: got %b need %b", name, bits, exp[W-1:0]); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || diff !== exp[W-1:0]) begin
      errors++; $display("FAIL %s post_done: done=%0b diff=%0d need done=0 diff=%0d", name, done, diff, exp[W-1:0]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; borrow_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, diff, borrow_out, diff_bit} !== '0) begin
      errors++; $display("FAIL reset_state: got busy=%0b done=%0b diff=%0d bo=%0b db=%0b need all 0", busy, done, diff, borrow_out, diff_bit);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    run_and_check("v100_37", 8'd100, 8'd37, 1'b0);
    run_and_check("v5_9", 8'd5, 8'd9, 1'b0);
    run_and_check("v0_0_b1", 8'd0, 8'd0, 1'b1);
    run_and_check("vFF_00", 8'hFF, 8'h00, 1'b0);
    run_and_check("v00_FF_b1", 8'h00, 8'hFF, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run_and_check($sformatf("rand%0d", i), W'($urandom), W'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_start_while_busy();
    int dones;
    @(negedge clk);
    a_in = 8'd100; b_in = 8'd37; borrow_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int c = 1; c <= 3 * W; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= 4) begin start = 1'b1; a_in = 8'd1; b_in = 8'd1; borrow_in = 1'b1; end
      else start = 1'b0;
      if (done) dones++;
    end
    checks++;
    if (dones !== 1) begin errors++; $display("FAIL busy_ignore_pulses: got %0d need 1", dones); end
    checks++;
    if (diff !== 8'd63 || borrow_out !== 1'b0) begin
      errors++; $display("FAIL busy_ignore_result: got %0d/%0b need 63/0", diff, borrow_out);
    end
  endtask

  task automatic test_reset_mid_shift();
    int dones;
    @(negedge clk);
    a_in = 8'd77; b_in = 8'd12; borrow_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, diff, borrow_out} !== '0) begin
      errors++; $display("FAIL abort_clear: got busy=%0b done=%0b diff=%0d bo=%0b need all 0", busy, done, diff, borrow_out);
    end
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    repeat (2 * W) begin @(negedge clk); if (done || busy) dones++; end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles need 0", dones); end
    run_and_check("after_abort", 8'd77, 8'd12, 1'b0);
  endtask

  task automatic test_back_to_back();
    int first_t;
    int second_t;
    int c;
    logic held_ok;
    @(negedge clk);
    a_in = 8'd200; b_in = 8'd55; borrow_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a_in = 8'd10; b_in = 8'd20;
    first_t = -1; second_t = -1; held_ok = 1'b1;
    c = 0;
    while (second_t < 0 && c < 4 * W) begin
      @(posedge clk); #1;
      c++;
      if (first_t >= 0) begin
        start = 1'b0;
        if (!done && diff !== 8'd145) held_ok = 1'b0;
      end
      if (done && first_t < 0) begin
        first_t = c;
        checks++;
        if (diff !== 8'd145 || borrow_out !== 1'b0) begin
          errors++; $display("FAIL b2b_first: got %0d/%0b need 145/0", diff, borrow_out);
        end
      end else if (done) begin
        second_t = c;
      end
    end
    start = 1'b0;
    checks++;
    if (second_t - first_t !== W + 1) begin
      errors++; $display("FAIL b2b_spacing: got %0d need %0d", second_t - first_t, W + 1);
    end
    checks++;
    if (diff !== 8'd246 || borrow_out !== 1'b1) begin
      errors++; $display("FAIL b2b_second: got %0d/%0b need 246/1", diff, borrow_out);
    end
    checks++;
    if (!held_ok) begin errors++; $display("FAIL b2b_hold: diff changed before second done, need 145"); end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_start_while_busy();
    test_reset_mid_shift();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
